alu_shift_pipe: RTL and testbench
=================================

Name: alu_shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the simple_processor ALU execute stage. It is the successor to the single-cycle shift unit.
- Supports SLL, SRL, SRA, ROL and ROR with register or immediate shift amount.
- Uses a valid/ready handshake, a configurable number of register stages, a sideband tag and a flush input.
- Sits between the operand-select logic and the writeback mux.

Parameters:
- DATA_WIDTH, 32 (from simple_processor_pkg): operand/result width; power of two, ≥ 8.
- NUM_STAGES, 2: pipeline register stages; legal range 1..SHIFT_WIDTH.
- TAG_WIDTH, 5: sideband tag width (e.g. rd index).
- SHIFT_WIDTH (localparam) = $clog2(DATA_WIDTH).
- LVLS_PER_STAGE (localparam) = ceil(SHIFT_WIDTH / NUM_STAGES).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid_i  in  1  input operation valid.
- in_ready_o  out  1  pipeline can accept an operation this cycle.
- rs1_data_i  in  DATA_WIDTH  value to shift.
- rs2_data_i  in  DATA_WIDTH  register shift amount; only bits [SHIFT_WIDTH-1:0] are used.
- imm_i  in  DATA_WIDTH  immediate shift amount; only bits [SHIFT_WIDTH-1:0] are used.
- use_imm_i  in  1  1 selects imm_i, 0 selects rs2_data_i.
- op_i  in  3  shift_op_e operation code.
- tag_i  in  TAG_WIDTH  sideband, carried unchanged to the output.
- flush_i  in  1  kill all in-flight operations.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  DATA_WIDTH  shifted result.
- tag_o  out  TAG_WIDTH  tag of the result.
- err_o  out  1  reserved opcode flag; qualified by out_valid_o.

Behaviour:
- Reset, sampled on posedge clk with rst_n=0:
  - All stage valid bits = 0.
  - out_valid_o=0, result_o=0, tag_o=0, err_o=0.
  - in_ready_o=1 in the first cycle after reset.
- Shift amount:
  - amt = use_imm_i ? imm_i[SHIFT_WIDTH-1:0] : rs2_data_i[SHIFT_WIDTH-1:0]. Upper bits are ignored.
  - amt=0 returns rs1 unchanged for every op.
- Datapath:
  - Right ops are bit-reversed at entry and at exit, so every mux level is a left shift.
  - Level i shifts by 2^i when amt[i]=1.
  - Fill bits: 0 for SLL/SRL; rs1[DATA_WIDTH-1] for SRA; wrapped-out bits for ROL/ROR.
  - Levels are grouped LVLS_PER_STAGE per register stage; the final stage may hold fewer levels.
  - Each stage register carries: valid, partial data, remaining amt bits, op, tag, sign bit, err.
- Latency: exactly NUM_STAGES cycles from an accepted input (in_valid_i & in_ready_o) to out_valid_o, absent stalls.
- Handshake:
  - adv = ~out_valid_o | out_ready_i. All stages move together on adv (global stall).
  - in_ready_o = adv. It is combinational from out_ready_i; no combinational path from in_valid_i.
  - While out_valid_o=1 and out_ready_i=0, result_o, tag_o and err_o hold stable.
  - Throughput: one operation per cycle when out_ready_i is held at 1.
  - Bubbles: an empty stage (valid=0) advances as a bubble.
- Flush:
  - flush_i=1 clears every valid bit on the next edge, including the output stage.
  - An input presented in the same cycle as flush is dropped.
  - Data registers need not clear.
  - Flush has priority over advance.
- Reserved opcodes (5..7): the operation flows normally, result_o=0 and err_o=1.
- Reset mid-operation: all in-flight operations are discarded; nothing emerges afterwards.

Decomposition:
- simple_processor_pkg contains:
  - shift_op_e: SH_SLL=3'd0, SH_SRL=1, SH_SRA=2, SH_ROL=3, SH_ROR=4.
  - The existing DATA_WIDTH.
- Sub-module alu_shift_stage:
  - Combinational group of LVLS_PER_STAGE mux levels.
  - Parameters: BASE_LVL, NUM_LVLS.
  - Inputs: data, amt slice, fill mode, sign.
  - Instantiated NUM_STAGES times in a generate loop; alu_shift_pipe owns all registers and the handshake.

Test Plan:
Configuration: DATA_WIDTH=32, NUM_STAGES=2.
- Basic ops:
  - SLL rs1=0x0000_00F1, rs2=4 → 0x0000_0F10.
  - SRA rs1=0x8000_0010, imm=4 (use_imm_i=1) → 0xF800_0001.
  - ROR rs1=0x0000_0001, amt=1 → 0x8000_0000.
  - Each result appears exactly 2 cycles after acceptance.
- Amount masking: SRL rs1=0xFFFF_FFFF, rs2=0x0000_0020 (amt=0) → 0xFFFF_FFFF; ROL rs1=0x1234_5678, amt=8 → 0x3456_7812.
- Back-to-back with stall:
  - Stream 4 ops, then hold out_ready_i=0 for 3 cycles.
  - Required: in_ready_o=0 during the stall, result_o/tag_o stable, no loss or duplication.
  - Tags must emerge in order 1,2,3,4.
- Flush: accept ops tag=7 and tag=8, assert flush_i one cycle later → out_valid_o stays 0; the next op (tag=9) emerges normally after 2 cycles.
- Reserved op and reset: op=3'd6 → out_valid_o=1, err_o=1, result_o=0. Assert rst_n=0 with 2 ops in flight → out_valid_o=0 for the following cycles; no stale result appears.
- Sweep: NUM_STAGES=1 and NUM_STAGES=5 with random ops/amounts checked against a reference model; latency equals NUM_STAGES.

Source files
------------

// File: rtl/simple_processor_pkg.sv
// rtl/simple_processor_pkg.sv - shared processor types and shift-unit helpers
//
// Purpose: processor-wide DATA_WIDTH, the shift opcode encoding, and the
// small decode helpers shared by the shift pipeline and its stage slices.
// Ports: none (package).

package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    SH_SLL = 3'd0,
    SH_SRL = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_op_e;

  // How vacated bit positions are filled while shifting left.
  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_ROT  = 2'd2
  } fill_mode_e;

  function automatic fill_mode_e op_fill(input logic [2:0] op);
    fill_mode_e f;
    case (op)
      SH_SRA:         f = FILL_SIGN;
      SH_ROL, SH_ROR: f = FILL_ROT;
      default:        f = FILL_ZERO;
    endcase
    return f;
  endfunction

  // Right-going ops are bit-reversed around a left-only shifter.
  function automatic logic op_is_right(input logic [2:0] op);
    return (op == SH_SRL) || (op == SH_SRA) || (op == SH_ROR);
  endfunction

  function automatic logic op_is_reserved(input logic [2:0] op);
    return op > SH_ROR;
  endfunction

endpackage

// File: rtl/alu_shift_stage.sv
// rtl/alu_shift_stage.sv - combinational group of left-shift mux levels
//
// Purpose: applies mux levels BASE_LVL .. BASE_LVL+NUM_LVLS-1 of a left barrel
// shifter; level k shifts by 2**k when its amount bit is set.
// Ports:
//   data_i  partial result entering this group
//   amt_i   amount bits for this group's levels (bit 0 -> level BASE_LVL)
//   fill_i  fill mode for vacated low bits
//   sign_i  original operand MSB, used as fill for arithmetic shifts
//   data_o  partial result leaving this group

module alu_shift_stage
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int BASE_LVL   = 0,
  parameter int NUM_LVLS   = 1
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [NUM_LVLS-1:0]   amt_i,
  input  fill_mode_e            fill_i,
  input  logic                  sign_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] d;
  logic [DATA_WIDTH-1:0] low_mask;
  int                    sh;

  always_comb begin
    d        = data_i;
    low_mask = '0;
    sh       = 0;
    for (int i = 0; i < NUM_LVLS; i++) begin
      if (amt_i[i]) begin
        sh       = 1 << (BASE_LVL + i);
        low_mask = ~({DATA_WIDTH{1'b1}} << sh);
        case (fill_i)
          FILL_SIGN: d = (d << sh) | (low_mask & {DATA_WIDTH{sign_i}});
          FILL_ROT:  d = (d << sh) | (d >> (DATA_WIDTH - sh));
          default:   d = d << sh;
        endcase
      end
    end
    data_o = d;
  end

endmodule

// File: rtl/alu_shift_pipe.sv
// rtl/alu_shift_pipe.sv - pipelined barrel shifter for the ALU execute stage
//
// Purpose: SLL/SRL/SRA/ROL/ROR with register or immediate amount, spread over
// NUM_STAGES register stages with a global-stall valid/ready handshake.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid_i/in_ready_o   input handshake
//   rs1_data_i              value to shift
//   rs2_data_i, imm_i       shift amount sources (low SHIFT_WIDTH bits used)
//   use_imm_i               1 selects imm_i
//   op_i                    shift opcode (5..7 reserved)
//   tag_i/tag_o             sideband carried alongside the operation
//   flush_i                 drops every in-flight operation
//   out_valid_o/out_ready_i output handshake
//   result_o, err_o         result and reserved-opcode flag

module alu_shift_pipe
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int NUM_STAGES = 2,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  use_imm_i,
  input  logic [2:0]            op_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  err_o
);

  localparam int SHIFT_WIDTH    = $clog2(DATA_WIDTH);
  localparam int LVLS_PER_STAGE = (SHIFT_WIDTH + NUM_STAGES - 1) / NUM_STAGES;
  localparam int LAST           = NUM_STAGES - 1;

  function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int b = 0; b < DATA_WIDTH; b++) r[b] = v[DATA_WIDTH-1-b];
    return r;
  endfunction

  // Stage registers; index LAST is the output register.
  logic [NUM_STAGES-1:0]  vld_q, vld_d;
  logic [DATA_WIDTH-1:0]  data_q [NUM_STAGES];
  logic [DATA_WIDTH-1:0]  data_d [NUM_STAGES];
  logic [SHIFT_WIDTH-1:0] amt_q  [NUM_STAGES];
  logic [SHIFT_WIDTH-1:0] amt_d  [NUM_STAGES];
  logic [2:0]             op_q   [NUM_STAGES];
  logic [2:0]             op_d   [NUM_STAGES];
  logic [TAG_WIDTH-1:0]   tag_q  [NUM_STAGES];
  logic [TAG_WIDTH-1:0]   tag_d  [NUM_STAGES];
  logic [NUM_STAGES-1:0]  sign_q, sign_d;
  logic [NUM_STAGES-1:0]  err_q, err_d;

  // Combinational inputs/outputs of each stage's mux group.
  logic [NUM_STAGES-1:0]  st_vld;
  logic [DATA_WIDTH-1:0]  st_data [NUM_STAGES];
  logic [SHIFT_WIDTH-1:0] st_amt  [NUM_STAGES];
  logic [2:0]             st_op   [NUM_STAGES];
  logic [TAG_WIDTH-1:0]   st_tag  [NUM_STAGES];
  logic [NUM_STAGES-1:0]  st_sign;
  logic [NUM_STAGES-1:0]  st_err;
  logic [DATA_WIDTH-1:0]  st_res  [NUM_STAGES];
  logic [DATA_WIDTH-1:0]  final_res;
  logic                   adv;

  // The output register has consumed its amount/op/sign; upper amount bits
  // of the operands are architecturally ignored.
  logic unused_bits;
  assign unused_bits = ^{amt_q[LAST], op_q[LAST], sign_q[LAST],
                         rs2_data_i[DATA_WIDTH-1:SHIFT_WIDTH],
                         imm_i[DATA_WIDTH-1:SHIFT_WIDTH]};

  assign adv        = ~vld_q[LAST] | out_ready_i;
  assign in_ready_o = adv;

  always_comb begin
    st_vld[0]  = in_valid_i;
    st_data[0] = op_is_right(op_i) ? bit_rev(rs1_data_i) : rs1_data_i;
    st_amt[0]  = use_imm_i ? imm_i[SHIFT_WIDTH-1:0] : rs2_data_i[SHIFT_WIDTH-1:0];
    st_op[0]   = op_i;
    st_tag[0]  = tag_i;
    st_sign[0] = rs1_data_i[DATA_WIDTH-1];
    st_err[0]  = op_is_reserved(op_i);
    for (int s = 1; s < NUM_STAGES; s++) begin
      st_vld[s]  = vld_q[s-1];
      st_data[s] = data_q[s-1];
      st_amt[s]  = amt_q[s-1];
      st_op[s]   = op_q[s-1];
      st_tag[s]  = tag_q[s-1];
      st_sign[s] = sign_q[s-1];
      st_err[s]  = err_q[s-1];
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int BASE  = s * LVLS_PER_STAGE;
    localparam int AVAIL = SHIFT_WIDTH - BASE;
    localparam int NLVL  = (AVAIL < LVLS_PER_STAGE) ? ((AVAIL > 0) ? AVAIL : 0)
                                                    : LVLS_PER_STAGE;
    if (NLVL > 0) begin : g_lvls
      alu_shift_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .BASE_LVL   (BASE),
        .NUM_LVLS   (NLVL)
      ) u_stage (
        .data_i (st_data[s]),
        .amt_i  (st_amt[s][BASE +: NLVL]),
        .fill_i (op_fill(st_op[s])),
        .sign_i (st_sign[s]),
        .data_o (st_res[s])
      );
    end else begin : g_pass
      // Trailing stages with no levels left are pure pipeline registers.
      assign st_res[s] = st_data[s];
    end
  end

  // Undo the entry reversal and squash reserved ops before the output register
  // so result_o comes straight from a flop.
  assign final_res = st_err[LAST] ? '0
                   : (op_is_right(st_op[LAST]) ? bit_rev(st_res[LAST]) : st_res[LAST]);

  always_comb begin
    vld_d  = vld_q;
    sign_d = sign_q;
    err_d  = err_q;
    for (int s = 0; s < NUM_STAGES; s++) begin
      data_d[s] = data_q[s];
      amt_d[s]  = amt_q[s];
      op_d[s]   = op_q[s];
      tag_d[s]  = tag_q[s];
    end
    if (flush_i) begin
      vld_d = '0;
    end else if (adv) begin
      vld_d  = st_vld;
      sign_d = st_sign;
      err_d  = st_err;
      for (int s = 0; s < NUM_STAGES; s++) begin
        data_d[s] = st_res[s];
        amt_d[s]  = st_amt[s];
        op_d[s]   = st_op[s];
        tag_d[s]  = st_tag[s];
      end
      data_d[LAST] = final_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sign_q <= '0;
      err_q  <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        data_q[s] <= '0;
        amt_q[s]  <= '0;
        op_q[s]   <= '0;
        tag_q[s]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      sign_q <= sign_d;
      err_q  <= err_d;
      for (int s = 0; s < NUM_STAGES; s++) begin
        data_q[s] <= data_d[s];
        amt_q[s]  <= amt_d[s];
        op_q[s]   <= op_d[s];
        tag_q[s]  <= tag_d[s];
      end
    end
  end

  assign out_valid_o = vld_q[LAST];
  assign result_o    = data_q[LAST];
  assign tag_o       = tag_q[LAST];
  assign err_o       = err_q[LAST];

endmodule

// File: tb/tb_alu_shift_pipe.sv
// tb/tb_alu_shift_pipe.sv - scoreboard bench for alu_shift_pipe (1, 2 and 5 stages)

module tb_alu_shift_pipe;

  localparam int DW = 32;
  localparam int TW = 5;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          err;
    int            acc;
    bit            exact;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_valid_g;
  logic [DW-1:0] rs1, rs2, imm;
  logic          use_imm;
  logic [2:0]    op_r;
  logic [TW-1:0] tag;
  logic          flush;
  logic          ordy0;

  logic          in_ready [3];
  logic          ov       [3];
  logic [DW-1:0] res      [3];
  logic [TW-1:0] tago     [3];
  logic          erro     [3];

  exp_t exp_q[$];
  int   rd_idx [3];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   exact_mode;
  bit   rand_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sweep copies see only the operations the 2-stage copy accepts.
  assign in_valid_g = in_valid & in_ready[0];

  alu_shift_pipe #(.DATA_WIDTH(DW), .NUM_STAGES(2), .TAG_WIDTH(TW)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm), .use_imm_i(use_imm),
    .op_i(op_r), .tag_i(tag), .flush_i(flush), .out_valid_o(ov[0]),
    .out_ready_i(ordy0), .result_o(res[0]), .tag_o(tago[0]), .err_o(erro[0]));

  alu_shift_pipe #(.DATA_WIDTH(DW), .NUM_STAGES(1), .TAG_WIDTH(TW)) dut_ns1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_g), .in_ready_o(in_ready[1]),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm), .use_imm_i(use_imm),
    .op_i(op_r), .tag_i(tag), .flush_i(flush), .out_valid_o(ov[1]),
    .out_ready_i(1'b1), .result_o(res[1]), .tag_o(tago[1]), .err_o(erro[1]));

  alu_shift_pipe #(.DATA_WIDTH(DW), .NUM_STAGES(5), .TAG_WIDTH(TW)) dut_ns5 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_g), .in_ready_o(in_ready[2]),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm), .use_imm_i(use_imm),
    .op_i(op_r), .tag_i(tag), .flush_i(flush), .out_valid_o(ov[2]),
    .out_ready_i(1'b1), .result_o(res[2]), .tag_o(tago[2]), .err_o(erro[2]));

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain shift/rotate arithmetic on the 5-bit amount.
  function automatic logic [DW:0] model(input logic [2:0] op, input logic [DW-1:0] a, input int n);
    logic [DW-1:0] r;
    logic          e;
    e = 1'b0;
    case (op)
      3'd0:    r = a << n;
      3'd1:    r = a >> n;
      3'd2:    r = DW'($signed(a) >>> n);
      3'd3:    r = (a << n) | (a >> (DW - n));
      3'd4:    r = (a >> n) | (a << (DW - n));
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] im, input logic ui, input logic [TW-1:0] t);
    int   tries;
    bit   done;
    int   n;
    exp_t e;
    op_r = op; rs1 = a; rs2 = b; imm = im; use_imm = ui; tag = t;
    in_valid = 1'b1;
    done = 0;
    tries = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready[0] && !flush && rst_n) begin
        n = ui ? int'(im[4:0]) : int'(b[4:0]);
        {e.err, e.res} = model(op, a, n);
        e.tag   = t;
        e.acc   = cyc;
        e.exact = exact_mode;
        exp_q.push_back(e);
        done = 1;
      end else if (++tries > 200) begin
        chk("accept_timeout", 32'(in_ready[0]), 32'd1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic discard_pending();
    for (int k = 0; k < 3; k++) rd_idx[k] = exp_q.size();
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_mon
    localparam int NSK = (k == 0) ? 2 : ((k == 1) ? 1 : 5);
    exp_t e;
    logic rdy;
    int   lat;
    always @(negedge clk) begin
      rdy = (k == 0) ? ordy0 : 1'b1;
      if (rst_n && !flush && ov[k] && rdy) begin
        if (rd_idx[k] >= exp_q.size()) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out dut%0d: got tag %0d result %h, expected no output", k, tago[k], res[k]);
        end else begin
          e = exp_q[rd_idx[k]];
          rd_idx[k]++;
          chk($sformatf("result_ns%0d", NSK), res[k], e.res);
          chk($sformatf("tag_ns%0d", NSK), 32'(tago[k]), 32'(e.tag));
          chk($sformatf("err_ns%0d", NSK), 32'(erro[k]), 32'(e.err));
          lat = cyc - e.acc;
          if (e.exact || k != 0) chk($sformatf("latency_ns%0d", NSK), 32'(lat), 32'(NSK));
          else chk("latency_min_ns2", 32'(lat >= NSK), 32'd1);
        end
      end
    end
  end

  // Handshake rule and stall stability on the 2-stage copy.
  bit            prev_stall = 0;
  logic [DW-1:0] prev_res;
  logic [TW-1:0] prev_tag;
  logic          prev_err;
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      chk("in_ready_rule", 32'(in_ready[0]), 32'(!ov[0] || ordy0));
      if (prev_stall) begin
        chk("hold_valid", 32'(ov[0]), 32'd1);
        chk("hold_result", res[0], prev_res);
        chk("hold_tag", 32'(tago[0]), 32'(prev_tag));
        chk("hold_err", 32'(erro[0]), 32'(prev_err));
      end
      prev_stall = ov[0] && !ordy0;
      prev_res   = res[0];
      prev_tag   = tago[0];
      prev_err   = erro[0];
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; imm = '0; use_imm = 1'b0;
    op_r = '0; tag = '0; flush = 1'b0; ordy0 = 1'b1; exact_mode = 1'b1; rand_busy = 1'b0;
    for (int k = 0; k < 3; k++) rd_idx[k] = 0;
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_out_valid", 32'(ov[k]), 32'd0);
      chk("reset_result", res[k], 32'd0);
      chk("reset_tag", 32'(tago[k]), 32'd0);
      chk("reset_err", 32'(erro[k]), 32'd0);
      chk("reset_in_ready", 32'(in_ready[k]), 32'd1);
    end
    @(posedge clk); #1;

    // Basic ops and amount masking, with gaps between them.
    drive(3'd0, 32'h0000_00F1, 32'd4, 32'd0, 1'b0, 5'd1);
    tick(3);
    drive(3'd2, 32'h8000_0010, 32'd0, 32'd4, 1'b1, 5'd2);
    tick(3);
    drive(3'd4, 32'h0000_0001, 32'd1, 32'd0, 1'b0, 5'd3);
    drive(3'd1, 32'hFFFF_FFFF, 32'h0000_0020, 32'd0, 1'b0, 5'd4);
    drive(3'd3, 32'h1234_5678, 32'd0, 32'h0000_0FE8, 1'b1, 5'd5);
    tick(8);

    // Back-to-back stream then a 3-cycle output stall.
    exact_mode = 1'b0;
    for (int i = 1; i <= 4; i++)
      drive(3'($urandom_range(0, 4)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'(i));
    ordy0 = 1'b0;
    tick(3);
    ordy0 = 1'b1;
    tick(8);
    exact_mode = 1'b1;

    // Flush one cycle after two accepted ops; the next op still flows.
    drive(3'd0, 32'h0000_0011, 32'd1, 32'd0, 1'b0, 5'd7);
    drive(3'd3, 32'h0000_0022, 32'd2, 32'd0, 1'b0, 5'd8);
    flush = 1'b1;
    discard_pending();
    tick(1);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(ov[0]), 32'd0);
    end
    @(posedge clk); #1;
    drive(3'd1, 32'hF000_0000, 32'd4, 32'd0, 1'b0, 5'd9);
    tick(8);

    // Reserved opcode.
    drive(3'd6, 32'hDEAD_BEEF, 32'd3, 32'd0, 1'b0, 5'd10);
    tick(8);

    // Reset with two ops in flight.
    drive(3'd0, 32'h0000_0001, 32'd1, 32'd0, 1'b0, 5'd11);
    drive(3'd4, 32'h0000_0100, 32'd2, 32'd0, 1'b0, 5'd12);
    rst_n = 1'b0;
    discard_pending();
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("post_reset_out_valid", 32'(ov[k]), 32'd0);
    end
    @(posedge clk); #1;

    // Random ops with random backpressure on the 2-stage copy.
    exact_mode = 1'b0;
    rand_busy = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 4) == 0) tick($urandom_range(1, 3));
          drive(($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom));
        end
        rand_busy = 1'b0;
      end
      begin
        while (rand_busy) begin
          @(posedge clk); #1;
          ordy0 = ($urandom_range(0, 3) != 0);
        end
        ordy0 = 1'b1;
      end
    join
    tick(20);
    for (int k = 0; k < 3; k++) chk("drained_count", 32'(rd_idx[k]), 32'(exp_q.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
